// File: rtl/mp_addsub_mod.sv
// mp_addsub_mod: limb-serial multi-precision add/sub with modular add/sub modes.
// Two carry chains run per limb: s = a +/- b, and t = s -/+ m for the modular correction.
module mp_addsub_mod #(
    parameter int OPERAND_W = 513,
    parameter int LIMB_W    = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [OPERAND_W-1:0] in_a,
    input  logic [OPERAND_W-1:0] in_b,
    input  logic [OPERAND_W-1:0] in_m,
    output logic [OPERAND_W:0]   result,
    output logic                 flag,
    output logic                 busy,
    output logic                 done
);
    localparam int NL = (OPERAND_W + LIMB_W - 1) / LIMB_W;
    localparam int PW = NL * LIMB_W;
    localparam int CW = NL > 1 ? $clog2(NL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [PW-1:0]     a_r, b_r, m_r, s_r, t_r;
    logic [1:0]        mode_r;
    logic [CW-1:0]     cnt;
    logic              c1, c2, c1_n, c2_n, corr, flag_n;
    logic [LIMB_W-1:0] s_l, t_l;
    logic [PW:0]       x;
    logic [OPERAND_W:0] res_n;

    // Operand registers shift right one limb per cycle; s/t fill from the top.
    always_comb begin
        {c1_n, s_l} = (LIMB_W+1)'(a_r[LIMB_W-1:0])
                    + (LIMB_W+1)'(b_r[LIMB_W-1:0] ^ {LIMB_W{mode_r[0]}})
                    + (LIMB_W+1)'(c1);
        {c2_n, t_l} = (LIMB_W+1)'(s_l)
                    + (LIMB_W+1)'(m_r[LIMB_W-1:0] ^ {LIMB_W{~mode_r[0]}})
                    + (LIMB_W+1)'(c2);
        corr   = mode_r[0] ? ~c1 : (c1 | c2);
        x      = {c1 ^ mode_r[0], s_r};
        res_n  = mode_r[1] ? {1'b0, (corr ? t_r[OPERAND_W-1:0] : s_r[OPERAND_W-1:0])} : x[OPERAND_W:0];
        flag_n = mode_r[1] ? corr : (mode_r[0] ? ~c1 : x[OPERAND_W]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            result <= '0;
            flag   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            c1     <= 1'b0;
            c2     <= 1'b0;
            mode_r <= 2'b00;
            a_r    <= '0;
            b_r    <= '0;
            m_r    <= '0;
            s_r    <= '0;
            t_r    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_r    <= PW'(in_a);
                    b_r    <= PW'(in_b);
                    m_r    <= PW'(in_m);
                    mode_r <= mode;
                    cnt    <= '0;
                    c1     <= mode[0];
                    c2     <= ~mode[0];
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    a_r <= a_r >> LIMB_W;
                    b_r <= b_r >> LIMB_W;
                    m_r <= m_r >> LIMB_W;
                    s_r <= PW'({s_l, s_r} >> LIMB_W);
                    t_r <= PW'({t_l, t_r} >> LIMB_W);
                    c1  <= c1_n;
                    c2  <= c2_n;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NL - 1)) state <= DONE;
                end
                DONE: begin
                    result <= res_n;
                    flag   <= flag_n;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mp_addsub_mod.sv
// tb_mp_addsub_mod: checks a default (513/64) and a narrow (13/4) instance against
// an exact-arithmetic reference model with directed and random operations.
module tb_mp_addsub_mod;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic [1:0] mode0 = 2'b00, mode1 = 2'b00;
    logic [512:0] a0 = '0, b0 = '0, m0 = '0;
    logic [12:0] a1 = '0, b1 = '0, m1 = '0;
    logic [513:0] r0;
    logic [13:0] r1;
    logic f0, f1, busy0, busy1, done0, done1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mp_addsub_mod dut0 (.clk(clk), .resetn(resetn), .start(start0), .mode(mode0),
        .in_a(a0), .in_b(b0), .in_m(m0), .result(r0), .flag(f0), .busy(busy0), .done(done0));

    mp_addsub_mod #(.OPERAND_W(13), .LIMB_W(4)) dut1 (.clk(clk), .resetn(resetn), .start(start1),
        .mode(mode1), .in_a(a1), .in_b(b1), .in_m(m1), .result(r1), .flag(f1), .busy(busy1), .done(done1));

    task automatic chk(input string tag, input logic [515:0] got, input logic [515:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int w, input logic [1:0] md, input logic [515:0] a, b, m,
                                  output logic [515:0] r, output logic f);
        logic [515:0] mask, s;
        mask = (516'd1 << (w + 1)) - 516'd1;
        s = a + b;
        case (md)
            2'b00: begin r = s & mask; f = r[w]; end
            2'b01: begin r = (a - b) & mask; f = a < b; end
            2'b10: begin f = s >= m; r = f ? s - m : s; end
            default: begin f = a < b; r = f ? a + m - b : a - b; end
        endcase
    endfunction

    function automatic logic [515:0] rnd(input int w);
        logic [527:0] v;
        v = '0;
        for (int i = 0; i < 17; i++) v = {v[495:0], $urandom()};
        return v[515:0] & ((516'd1 << w) - 516'd1);
    endfunction

    task automatic op(input bit s, input logic [1:0] md, input logic [515:0] a, b, m, input string tag);
        int w, nl, n, bc;
        logic [515:0] er, got;
        logic ef, seen;
        w = s ? 13 : 513;
        nl = s ? 4 : 9;
        model(w, md, a, b, m, er, ef);
        @(negedge clk);
        if (s) begin start1 = 1'b1; mode1 = md; a1 = a[12:0]; b1 = b[12:0]; m1 = m[12:0]; end
        else begin start0 = 1'b1; mode0 = md; a0 = a[512:0]; b0 = b[512:0]; m0 = m[512:0]; end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        a0 = ~a0; b0 = ~b0; m0 = m0 ^ 513'd1; mode0 = ~mode0;
        a1 = ~a1; b1 = ~b1; m1 = m1 ^ 13'd1; mode1 = ~mode1;
        n = 0; bc = 0; seen = 1'b0;
        while (!seen && n < nl + 6) begin
            @(negedge clk);
            bc += int'(s ? busy1 : busy0);
            @(posedge clk); #1;
            n++;
            seen = s ? done1 : done0;
        end
        got = s ? {502'b0, r1} : {2'b0, r0};
        chk({tag, " latency"}, n, nl + 1);
        chk({tag, " busy cycles"}, bc, nl + 1);
        chk({tag, " result"}, got, er);
        chk({tag, " flag"}, s ? f1 : f0, ef);
        @(posedge clk); #1;
        chk({tag, " done pulse"}, s ? done1 : done0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [515:0] ones, a, b, m;
        int nd, d0, d1, n;
        ones = (516'd1 << 513) - 516'd1;
        #2;
        chk("reset result", r0, 0);
        chk("reset flag", f0, 0);
        chk("reset busy", busy0, 0);
        chk("reset done", done0, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        op(0, 2'b00, 1, 1, 0, "add 1+1");
        op(0, 2'b00, ones, 1, 0, "add max+1");
        op(0, 2'b01, 1, 1, 0, "sub 1-1");
        op(0, 2'b01, 0, 1, 0, "sub 0-1");
        op(0, 2'b10, 12, 5, 13, "madd 12+5");
        op(0, 2'b10, 3, 4, 13, "madd 3+4");
        op(0, 2'b11, 3, 5, 13, "msub 3-5");
        op(0, 2'b11, 9, 4, 13, "msub 9-4");
        op(0, 2'b10, ones - 1, 2, ones, "madd big");
        op(0, 2'b11, 2, ones - 1, ones, "msub big");
        op(1, 2'b00, 16'h1FFF, 16'h1FFF, 0, "n add max");
        op(1, 2'b01, 0, 1, 0, "n sub 0-1");
        op(1, 2'b10, 16'h1FFE, 16'h1FFD, 16'h1FFF, "n madd top");

        for (int i = 0; i < 6; i++)
            for (int md = 0; md < 4; md++)
                for (int s = 0; s < 2; s++) begin
                    m = rnd(s ? 13 : 513);
                    if (m == 0) m = 1;
                    a = rnd(s ? 13 : 513);
                    b = rnd(s ? 13 : 513);
                    if (md >= 2) begin a = a % m; b = b % m; end
                    op(s[0], md[1:0], a, b, m, "random");
                end

        // start held high: back-to-back ops, one per IDLE visit
        @(negedge clk);
        start0 = 1'b1; mode0 = 2'b00; a0 = 513'd20; b0 = 513'd22;
        nd = 0; d0 = -1; d1 = -1;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk); #1;
            if (done0) begin
                if (nd == 0) d0 = e; else if (nd == 1) d1 = e;
                nd++;
            end
        end
        start0 = 1'b0;
        chk("held start count", nd, 2);
        chk("held start first", d0, 10);
        chk("held start second", d1, 21);
        chk("held start result", r0, 42);
        n = 0;
        while (!done0 && n < 20) begin @(posedge clk); #1; n++; end
        chk("held start drain", done0, 1);

        // operand change mid-operation
        @(negedge clk);
        start0 = 1'b1; mode0 = 2'b00; a0 = 513'd5; b0 = 513'd7;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 a0 = 513'd100; b0 = 513'd200;
        n = 0;
        while (!done0 && n < 15) begin @(posedge clk); #1; n++; end
        chk("late change result", r0, 12);

        // reset mid-operation
        @(negedge clk);
        start0 = 1'b1; mode0 = 2'b00; a0 = 513'd3; b0 = 513'd4;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("abort result", r0, 0);
        chk("abort busy", busy0, 0);
        chk("abort done", done0, 0);
        @(negedge clk);
        resetn = 1'b1;
        nd = 0;
        for (int e = 0; e < 14; e++) begin
            @(posedge clk); #1;
            nd += int'(done0);
        end
        chk("abort no done", nd, 0);
        op(0, 2'b00, 1, 1, 0, "post reset add");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
